// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile feeder and its skew network.
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DONE
   } feeder_state_e;

   // A skewed n x n tile drains in 2n-1 beats.
   function automatic int beat_count(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int lane_lsb(input int lane, input int w);
      return lane * w;
   endfunction

endpackage

// File: rtl/skew_select.sv
// Combinational diagonal skew: lane r presents row r of the tile delayed r beats.
module skew_select
   import systolic_pkg::*;
#(
   parameter int width_p = 8,
   parameter int n_p     = 4,
   parameter int t_w_p   = $clog2(2 * n_p)
) (
   input  logic                                 en_i,
   input  logic [t_w_p-1:0]                     t_i,
   input  logic [n_p*n_p-1:0][width_p-1:0]      tile_i,
   output logic [n_p*width_p-1:0]               lane_data_o,
   output logic [n_p-1:0]                       lane_valid_o
);

   for (genvar r = 0; r < n_p; r++) begin : g_lane
      logic [width_p-1:0] d;
      logic               v;

      // Column t-r is present only when the beat has reached this lane and not run past it.
      always_comb begin
         d = '0;
         v = 1'b0;
         for (int c = 0; c < n_p; c++) begin
            if (en_i && t_i == t_w_p'(r + c)) begin
               v = 1'b1;
               d = tile_i[r*n_p+c];
            end
         end
      end

      assign lane_data_o[lane_lsb(r, width_p) +: width_p] = d;
      assign lane_valid_o[r] = v;
   end

endmodule

// File: rtl/systolic_tile_feeder.sv
// Loads an n_p x n_p tile from an async-read RAM, then streams it skewed into a systolic array edge.
module systolic_tile_feeder
   import systolic_pkg::*;
#(
   parameter int width_p = 8,
   parameter int n_p     = 4,
   parameter int depth_p = 128
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          start_i,
   input  logic [$clog2(depth_p)-1:0]    base_addr_i,
   output logic [$clog2(depth_p)-1:0]    rd_addr_o,
   input  logic [width_p-1:0]            rd_data_i,
   output logic [n_p*width_p-1:0]        lane_data_o,
   output logic [n_p-1:0]                lane_valid_o,
   output logic                          beat_valid_o,
   input  logic                          ready_i,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int AW    = $clog2(depth_p);
   localparam int IW    = $clog2(n_p * n_p + 1);
   localparam int TW    = $clog2(2 * n_p);
   localparam int ELEMS = n_p * n_p;
   localparam int BEATS = beat_count(n_p);

   feeder_state_e                   state_q;
   logic [AW-1:0]                   base_q;
   logic [IW-1:0]                   idx_q;
   logic [TW-1:0]                   t_q;
   logic [ELEMS-1:0][width_p-1:0]   tile_q;
   logic                            busy_q;
   logic                            done_q;
   logic                            beat_vld_q;

   // Address adds in AW bits so a tile straddling the top of the RAM wraps to 0.
   assign rd_addr_o = (state_q == ST_LOAD) ? base_q + AW'(idx_q) : '0;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         t_q        <= '0;
         tile_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         beat_vld_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  base_q  <= base_addr_i;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               for (int e = 0; e < ELEMS; e++) begin
                  if (idx_q == IW'(e)) tile_q[e] <= rd_data_i;
               end
               idx_q <= idx_q + IW'(1);
               if (idx_q == IW'(ELEMS - 1)) begin
                  t_q        <= '0;
                  beat_vld_q <= 1'b1;
                  state_q    <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (ready_i) begin
                  if (t_q == TW'(BEATS - 1)) begin
                     beat_vld_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= ST_DONE;
                  end else begin
                     t_q <= t_q + TW'(1);
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               t_q     <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign beat_valid_o = beat_vld_q;

   skew_select #(
      .width_p (width_p),
      .n_p     (n_p),
      .t_w_p   (TW)
   ) u_skew (
      .en_i         (beat_vld_q),
      .t_i          (t_q),
      .tile_i       (tile_q),
      .lane_data_o  (lane_data_o),
      .lane_valid_o (lane_valid_o)
   );

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Directed bench for systolic_tile_feeder with a transfer-level reference model checked every cycle.
module tb_systolic_tile_feeder;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [6:0]  base_addr_i;
   logic [6:0]  rd_addr_o;
   logic [7:0]  rd_data_i;
   logic [31:0] lane_data_o;
   logic [3:0]  lane_valid_o;
   logic        beat_valid_o;
   logic        ready_i;
   logic        busy_o;
   logic        done_o;

   logic [7:0]  ram [128];
   int          errs = 0;
   int          checks = 0;

   always #5 clk_i = ~clk_i;
   assign rd_data_i = ram[rd_addr_o];

   systolic_tile_feeder #(.width_p(8), .n_p(4), .depth_p(128)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .rd_addr_o    (rd_addr_o),
      .rd_data_i    (rd_data_i),
      .lane_data_o  (lane_data_o),
      .lane_valid_o (lane_valid_o),
      .beat_valid_o (beat_valid_o),
      .ready_i      (ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: a pending load of 16 words, then a beat index walked by accepted handshakes.
   int         m_ld_left, m_ld_pos, m_beat, m_base;
   bit         m_done;
   logic [7:0] mtile [16];

   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         m_ld_left <= 0;
         m_ld_pos  <= 0;
         m_beat    <= -1;
         m_done    <= 1'b0;
         m_base    <= 0;
      end else if (m_ld_left > 0) begin
         m_ld_left <= m_ld_left - 1;
         m_ld_pos  <= m_ld_pos + 1;
         if (m_ld_left == 1) m_beat <= 0;
      end else if (m_beat >= 0) begin
         if (ready_i) begin
            if (m_beat == 6) begin
               m_beat <= -1;
               m_done <= 1'b1;
            end else begin
               m_beat <= m_beat + 1;
            end
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (start_i) begin
         m_base    <= int'(base_addr_i);
         m_ld_left <= 16;
         m_ld_pos  <= 0;
         for (int i = 0; i < 16; i++) mtile[i] <= ram[(int'(base_addr_i) + i) % 128];
      end
   end

   always @(negedge clk_i) begin : compare
      logic [31:0] ed;
      logic [3:0]  ev;
      int          c;
      ed = '0;
      ev = '0;
      for (int r = 0; r < 4; r++) begin
         c = m_beat - r;
         if (m_beat >= 0 && c >= 0 && c < 4) begin
            ev[r] = 1'b1;
            ed[r*8 +: 8] = mtile[r*4+c];
         end
      end
      chk("lane_data", 64'(lane_data_o), 64'(ed));
      chk("lane_valid", 64'(lane_valid_o), 64'(ev));
      chk("beat_valid", 64'(beat_valid_o), 64'(m_beat >= 0));
      chk("busy", 64'(busy_o), 64'(m_ld_left > 0 || m_beat >= 0));
      chk("done", 64'(done_o), 64'(m_done));
      chk("rd_addr", 64'(rd_addr_o), (m_ld_left > 0) ? 64'((m_base + m_ld_pos) % 128) : 64'd0);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic begin_xfer(input logic [6:0] base);
      base_addr_i = base;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   logic [6:0] exp_wrap [16];
   int         nd;

   initial begin
      reset_i     = 1'b0;
      start_i     = 1'b0;
      ready_i     = 1'b1;
      base_addr_i = '0;
      for (int i = 0; i < 128; i++) ram[i] = 8'(i ^ 8'h5A);
      for (int i = 0; i < 16; i++) ram[16+i] = 8'(i + 1);
      for (int i = 0; i < 16; i++) ram[(124+i) % 128] = 8'(8'hA0 + i);
      for (int i = 0; i < 16; i++) exp_wrap[i] = 7'((124 + i) % 128);
      tick();
      tick();
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_lanes", 64'(lane_data_o), 64'd0);
      chk("rst_addr", 64'(rd_addr_o), 64'd0);
      reset_i = 1'b1;
      tick();

      // Nominal tile, ready held high.
      begin_xfer(7'h10);
      for (int c = 1; c <= 25; c++) begin
         if (c <= 16) chk("t1_addr", 64'(rd_addr_o), 64'(8'h10 + c - 1));
         if (c == 17) begin
            chk("t1_beat0", 64'(lane_data_o), 64'h00000001);
            chk("t1_beat0_v", 64'(lane_valid_o), 64'h1);
         end
         if (c == 20) begin
            chk("t1_beat3", 64'(lane_data_o), 64'h0D0A0704);
            chk("t1_beat3_v", 64'(lane_valid_o), 64'hF);
         end
         if (c == 23) begin
            chk("t1_beat6", 64'(lane_data_o), 64'h10000000);
            chk("t1_beat6_v", 64'(lane_valid_o), 64'h8);
         end
         chk("t1_done", 64'(done_o), 64'(c == 24));
         tick();
      end

      // Three-cycle stall on beat 2.
      begin_xfer(7'h10);
      for (int c = 1; c <= 29; c++) begin
         if (c == 19) ready_i = 1'b0;
         if (c == 22) ready_i = 1'b1;
         if (c >= 19 && c <= 22) begin
            chk("t2_hold", 64'(lane_data_o), 64'h00090603);
            chk("t2_hold_v", 64'(lane_valid_o), 64'h7);
         end
         if (c == 23) chk("t2_beat3", 64'(lane_data_o), 64'h0D0A0704);
         chk("t2_done", 64'(done_o), 64'(c == 27));
         tick();
      end

      // Tile straddling the top of the RAM.
      begin_xfer(7'h7C);
      for (int c = 1; c <= 25; c++) begin
         if (c <= 16) chk("t3_addr", 64'(rd_addr_o), 64'(exp_wrap[c-1]));
         if (c == 17) chk("t3_beat0", 64'(lane_data_o), 64'h000000A0);
         if (c == 23) chk("t3_beat6", 64'(lane_data_o), 64'hAF000000);
         chk("t3_done", 64'(done_o), 64'(c == 24));
         tick();
      end

      // Spurious starts during LOAD and STREAM.
      begin_xfer(7'h10);
      nd = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5 || c == 18) begin
            start_i = 1'b1;
            base_addr_i = 7'h40;
         end
         if (c == 6 || c == 19) start_i = 1'b0;
         if (c <= 23) chk("t4_busy", 64'(busy_o), 64'd1);
         if (c == 20) chk("t4_beat3", 64'(lane_data_o), 64'h0D0A0704);
         nd += int'(done_o);
         tick();
      end
      chk("t4_ndone", 64'(nd), 64'd1);

      // Asynchronous reset at LOAD idx 7.
      begin_xfer(7'h10);
      for (int c = 1; c < 8; c++) tick();
      chk("t5_pre_addr", 64'(rd_addr_o), 64'h17);
      #2 reset_i = 1'b0;
      #1;
      chk("t5_addr", 64'(rd_addr_o), 64'd0);
      chk("t5_busy", 64'(busy_o), 64'd0);
      chk("t5_bv", 64'(beat_valid_o), 64'd0);
      chk("t5_lanes", 64'(lane_data_o), 64'd0);
      chk("t5_lv", 64'(lane_valid_o), 64'd0);
      chk("t5_done", 64'(done_o), 64'd0);
      tick();
      tick();
      reset_i = 1'b1;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         nd += int'(done_o);
         tick();
      end
      chk("t5_ndone", 64'(nd), 64'd0);
      begin_xfer(7'h10);
      for (int c = 1; c <= 25; c++) begin
         if (c == 20) chk("t5_beat3", 64'(lane_data_o), 64'h0D0A0704);
         chk("t5_done2", 64'(done_o), 64'(c == 24));
         tick();
      end

      // Start held high: second LOAD begins after the IDLE cycle following DONE.
      base_addr_i = 7'h10;
      start_i     = 1'b1;
      tick();
      for (int c = 1; c <= 50; c++) begin
         if (c == 2) base_addr_i = 7'h7C;
         if (c == 24) begin
            chk("t6_done_busy", 64'(busy_o), 64'd0);
            chk("t6_done", 64'(done_o), 64'd1);
         end
         if (c == 25) chk("t6_idle_busy", 64'(busy_o), 64'd0);
         if (c == 26) begin
            chk("t6_reload_busy", 64'(busy_o), 64'd1);
            chk("t6_reload_addr", 64'(rd_addr_o), 64'h7C);
            start_i = 1'b0;
         end
         if (c == 42) chk("t6_beat0", 64'(lane_data_o), 64'h000000A0);
         if (c > 26) chk("t6_done2", 64'(done_o), 64'(c == 49));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
